// File: rtl/cart_header_probe_pkg.sv
// Header byte offsets and FSM states shared by the cartridge header probe.
package cart_pkg;

  localparam int unsigned HDR_CGB   = 'h142;
  localparam int unsigned HDR_TYPE  = 'h146;
  localparam int unsigned HDR_SIZE  = 'h148;
  localparam int unsigned HDR_LIC   = 'h14A;
  localparam int unsigned HDR_CHK   = 'h14C;
  localparam int unsigned LOGO_BASE = 'h104;
  localparam int unsigned CHK_FIRST = 'h134;
  localparam int unsigned CHK_WORDS = (HDR_CHK - CHK_FIRST) / 2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FINISH  = 2'd2
  } cart_state_e;

endpackage

// File: rtl/cart_header_probe_if.sv
// Download-side strobes in, decoded header fields and probe results out.
interface cart_header_probe_if #(
  parameter int unsigned ADDR_W   = 25,
  parameter int unsigned N_PROBES = 4
);
  logic                cart_download;
  logic                ioctl_wr;
  logic [ADDR_W-1:0]   ioctl_addr;
  logic [15:0]         ioctl_dout;
  logic [7:0]          mbc_type;
  logic [7:0]          rom_size;
  logic [7:0]          ram_size;
  logic                cgb_flag;
  logic [7:0]          sgb_flag;
  logic [7:0]          old_licensee;
  logic [8:0]          rom_mask;
  logic                hdr_chk_ok;
  logic [N_PROBES-1:0] probe_match;
  logic                hdr_valid;
  logic                done;

  modport master (
    output cart_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  mbc_type, rom_size, ram_size, cgb_flag, sgb_flag, old_licensee,
           rom_mask, hdr_chk_ok, probe_match, hdr_valid, done
  );

  modport slave (
    input  cart_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output mbc_type, rom_size, ram_size, cgb_flag, sgb_flag, old_licensee,
           rom_mask, hdr_chk_ok, probe_match, hdr_valid, done
  );
endinterface

// File: rtl/cart_logo_probe.sv
// One probe point: tracks whether every logo word seen so far matched bank 0.
module cart_logo_probe #(
  parameter int unsigned LOGO_WORDS = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic word_hit_i,
  input  logic word_eq_i,
  output logic match_o
);
  localparam int unsigned SEEN_W = $clog2(LOGO_WORDS + 2);
  localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(LOGO_WORDS + 1);

  logic              all_eq_q, all_eq_d;
  logic [SEEN_W-1:0] seen_q, seen_d;

  // Saturate one past LOGO_WORDS so repeated words can never wrap back to a match.
  always_comb begin
    all_eq_d = all_eq_q;
    seen_d   = seen_q;
    if (clear_i) begin
      all_eq_d = 1'b1;
      seen_d   = '0;
    end else if (word_hit_i) begin
      all_eq_d = all_eq_q & word_eq_i;
      if (seen_q != SEEN_MAX) seen_d = seen_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      all_eq_q <= 1'b0;
      seen_q   <= '0;
    end else begin
      all_eq_q <= all_eq_d;
      seen_q   <= seen_d;
    end
  end

  assign match_o = all_eq_q && (seen_q == SEEN_W'(LOGO_WORDS));
endmodule

// File: rtl/cart_header_probe.sv
// Snoops the ROM download, decodes Game Boy header fields, checks $14D and
// compares the Nintendo logo at each probe bank against bank 0.
module cart_header_probe
  import cart_pkg::*;
#(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned N_PROBES    = 4,
  parameter int unsigned PROBE_SHIFT = 18,
  parameter int unsigned LOGO_WORDS  = 8
) (
  input  logic               clk_sys,
  input  logic               reset,
  cart_header_probe_if.slave bus
);
  localparam int unsigned LOGO_LAST = LOGO_BASE + 2 * (LOGO_WORDS - 1);
  localparam int unsigned LIDX_W    = (LOGO_WORDS > 1) ? $clog2(LOGO_WORDS) : 1;
  localparam int unsigned CIDX_W    = $clog2(CHK_WORDS);

  cart_state_e          state_q, state_d;
  logic                 dl_q, pend_q, rise, fall, enter, take, done;
  logic [ADDR_W-1:0]    addr;
  logic [15:0]          dout;
  logic [7:0]           mbc_q, rom_q, ram_q, sgb_q, lic_q, acc_q, chk_byte_q, chk_sub;
  logic                 cgb_q, chk_ok_q, valid_q, logo_hit, chk_hit;
  logic [8:0]           rom_mask_q;
  logic [CHK_WORDS-1:0] chk_seen_q;
  logic [N_PROBES-1:0]  pm_q, pm_now;
  logic [15:0]          logo_q [LOGO_WORDS];
  logic [LIDX_W-1:0]    logo_idx;
  logic [CIDX_W-1:0]    chk_idx;

  assign addr     = bus.ioctl_addr;
  assign dout     = bus.ioctl_dout;
  assign rise     = bus.cart_download & ~dl_q;
  assign fall     = ~bus.cart_download & dl_q;
  assign take     = (state_q == ST_CAPTURE) & bus.ioctl_wr;
  assign logo_hit = take && addr >= ADDR_W'(LOGO_BASE) && addr <= ADDR_W'(LOGO_LAST);
  assign logo_idx = LIDX_W'((addr - ADDR_W'(LOGO_BASE)) >> 1);
  assign chk_hit  = take && addr >= ADDR_W'(CHK_FIRST) && addr <= ADDR_W'(HDR_CHK);
  assign chk_idx  = CIDX_W'((addr - ADDR_W'(CHK_FIRST)) >> 1);
  // The $14C word carries the checksum itself in its high byte.
  assign chk_sub  = (addr == ADDR_W'(HDR_CHK)) ? dout[7:0] + 8'd1
                                               : dout[7:0] + dout[15:8] + 8'd2;

  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise || pend_q) begin
          state_d = ST_CAPTURE;
          enter   = 1'b1;
        end
      end
      ST_CAPTURE: if (fall) state_d = ST_FINISH;
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // dl_q resets high so a download still asserted across reset is not re-taken.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dl_q       <= 1'b1;
      pend_q     <= 1'b0;
      mbc_q      <= '0;
      rom_q      <= '0;
      ram_q      <= '0;
      sgb_q      <= '0;
      lic_q      <= '0;
      cgb_q      <= 1'b0;
      acc_q      <= '0;
      chk_byte_q <= '0;
      chk_seen_q <= '0;
      chk_ok_q   <= 1'b0;
      rom_mask_q <= '0;
      pm_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= bus.cart_download;
      pend_q  <= (state_q == ST_FINISH) & rise;
      if (enter) begin
        mbc_q      <= '0;
        rom_q      <= '0;
        ram_q      <= '0;
        sgb_q      <= '0;
        lic_q      <= '0;
        cgb_q      <= 1'b0;
        acc_q      <= '0;
        chk_byte_q <= '0;
        chk_seen_q <= '0;
        chk_ok_q   <= 1'b0;
        rom_mask_q <= '0;
        pm_q       <= '0;
        valid_q    <= 1'b0;
      end else if (take) begin
        if (addr == ADDR_W'(HDR_CGB))  cgb_q <= dout[15];
        if (addr == ADDR_W'(HDR_TYPE)) {mbc_q, sgb_q} <= dout;
        if (addr == ADDR_W'(HDR_SIZE)) {ram_q, rom_q} <= dout;
        if (addr == ADDR_W'(HDR_LIC))  lic_q <= dout[15:8];
        if (addr == ADDR_W'(HDR_CHK))  chk_byte_q <= dout[15:8];
        if (chk_hit) begin
          acc_q               <= acc_q - chk_sub;
          chk_seen_q[chk_idx] <= 1'b1;
        end
        rom_mask_q <= rom_mask_q | addr[22:14];
      end
      if (state_q == ST_FINISH) begin
        valid_q  <= 1'b1;
        chk_ok_q <= (&chk_seen_q) && (acc_q == chk_byte_q);
        pm_q     <= pm_now;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (logo_hit) logo_q[logo_idx] <= dout;
  end

  for (genvar k = 0; k < N_PROBES; k++) begin : g_probe
    localparam int unsigned BASE = (k + 1) << PROBE_SHIFT;
    logic [ADDR_W-1:0] off;
    logic              hit, eq;

    assign off = addr - ADDR_W'(BASE);
    assign hit = take && off >= ADDR_W'(LOGO_BASE) && off <= ADDR_W'(LOGO_LAST);
    assign eq  = dout == logo_q[LIDX_W'((off - ADDR_W'(LOGO_BASE)) >> 1)];

    cart_logo_probe #(.LOGO_WORDS(LOGO_WORDS)) u_probe (
      .clk_i     (clk_sys),
      .rst_i     (reset),
      .clear_i   (enter),
      .word_hit_i(hit),
      .word_eq_i (eq),
      .match_o   (pm_now[k])
    );
  end

  assign bus.mbc_type     = mbc_q;
  assign bus.rom_size     = rom_q;
  assign bus.ram_size     = ram_q;
  assign bus.cgb_flag     = cgb_q;
  assign bus.sgb_flag     = sgb_q;
  assign bus.old_licensee = lic_q;
  assign bus.rom_mask     = rom_mask_q;
  assign bus.hdr_chk_ok   = chk_ok_q;
  assign bus.probe_match  = pm_q;
  assign bus.hdr_valid    = valid_q;
  assign bus.done         = done;
endmodule
